frl_checkpoint_ctrl: RTL and testbench
======================================

Name: frl_checkpoint_ctrl

Overview:
- Manages speculative checkpoints of the physical free register lists (data and status register files) for the out-of-order core.
- On each branch dispatch it snapshots the free lists' next state into a circular checkpoint buffer and tags the branch with a checkpoint ID.
- While a snapshot is live, it merges commit-time register returns into it.
- On a mispredict it drives the restore strobe and the restored lists to the free register list, and discards the mispredicted checkpoint and all younger ones.

Parameters:
- NUM_D_REG, 32, number of physical data registers (free-list bits).
- NUM_S_REG, 8, number of physical status registers.
- NUM_CKPT, 4, checkpoint slots (power of two, at least 2).

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous active-low reset.
- branch_valid  in  1  a branch dispatches this cycle and requests a checkpoint.
- r_free_next  in  NUM_D_REG  data free list as it will be after this cycle's checkout and commit.
- s_free_next  in  NUM_S_REG  status free list, same timing as r_free_next.
- ckpt_full  out  1  all slots live; dispatch must stall branches.
- ckpt_id  out  $clog2(NUM_CKPT)  slot the dispatching branch receives (the tail index).
- resolve_valid  in  1  a branch resolves this cycle.
- resolve_id  in  $clog2(NUM_CKPT)  checkpoint ID of the resolving branch.
- resolve_mispredict  in  1  the resolving branch was mispredicted.
- return_r  in  1  commit returns a data register this cycle.
- return_r_addr  in  $clog2(NUM_D_REG)  returned data register.
- return_s  in  1  commit returns a status register this cycle.
- return_s_addr  in  $clog2(NUM_S_REG)  returned status register.
- restore  out  1  restore strobe to the free register list.
- restore_r_free  out  NUM_D_REG  data free list to load.
- restore_s_free  out  NUM_S_REG  status free list to load.
- count  out  $clog2(NUM_CKPT)+1  number of live slots.

Behaviour:
- State:
  - head and tail pointers, each $clog2(NUM_CKPT)+1 bits including a wrap bit.
  - Per slot: live, resolved, r_snap, s_snap.
  - Registered restore buffer plus rst_pend flag.
- count = tail - head. ckpt_full = (count == NUM_CKPT). ckpt_id = tail index bits. All three are combinational from registers.
- Reset (n_rst == 0 at a clk edge):
  - head = tail = 0; all live and resolved cleared; rst_pend = 0.
  - Outputs after reset: restore = 0, ckpt_full = 0, count = 0, ckpt_id = 0, restore_r_free = 0, restore_s_free = 0.
  - Reset mid-operation discards all checkpoints with no restore pulse.
- Allocate: if branch_valid and not ckpt_full and no mispredict this cycle:
  - r_snap/s_snap[tail] = r_free_next/s_free_next.
  - live = 1, resolved = 0, tail++.
  - branch_valid while full is ignored; no state change.
- Commit merge: each cycle, for every live slot not being allocated this cycle, return_r sets r_snap[return_r_addr] = 1, and likewise return_s for s_snap.
- Correct resolve (resolve_valid and not resolve_mispredict, slot live): set resolved[resolve_id]. A resolve_id whose slot is not live is ignored.
- Retire: each cycle, if slot[head] is live and resolved (including a resolve setting it this cycle), clear live and advance head by 1. At most one retire per cycle.
- Mispredict (resolve_valid and resolve_mispredict, slot live, id k):
  - The restore buffer captures r_snap[k]/s_snap[k] with this cycle's returns OR-ed in, and rst_pend = 1.
  - tail is set to k with its wrap bit chosen so that count shrinks. Slot k and all younger slots lose live.
  - A same-cycle branch_valid is dropped (that branch is being flushed).
  - A retire at head is still permitted if head is older than k.
- Restore output:
  - restore = rst_pend for exactly one cycle, i.e. 1 cycle after the mispredict input.
  - restore_r_free = buffer | onehot(return_r_addr) when return_r; same for s. Commits concurrent with restore are never lost.
  - rst_pend clears the next cycle.
  - When restore is 0, restore_*_free hold 0.
- A mispredict of the oldest live slot empties the buffer (count = 0).
- Pointers wrap modulo NUM_CKPT; the wrap bit distinguishes full from empty.

Test Plan:
- Reset, then 4 branch_valid with r_free_next = 32'h0000_FFF0, 32'h0000_FFE0, 32'h0000_FFC0, 32'h0000_FF80 -> ckpt_id 0,1,2,3; count = 4; ckpt_full = 1; a 5th branch_valid is ignored.
- After the previous test, commit return_r, return_r_addr = 2 -> then mispredict id 1 -> next cycle restore = 1, restore_r_free = 32'h0000_FFE4, count = 1, ckpt_id = 1.
- Mispredict id 0 with a same-cycle return_s, addr 5 -> restore_s_free includes bit 5; same cycle return_s addr 6 during restore -> bit 6 also set; count = 0.
- Correct resolve ids 1 then 0 (out of order) -> head stays put until id 0 resolves, then advances 1 per cycle; count goes 4 -> 3 -> 2.
- branch_valid and mispredict id 2 in the same cycle with 3 live -> branch dropped, count = 2, restore pulse of one cycle.
- Assert n_rst for one cycle one cycle after the mispredict input (cycle restore would assert) -> restore stays 0, count = 0, ckpt_full = 0.

Source files
------------

// File: rtl/frl_checkpoint_ctrl_if.sv
// Bundle between dispatch/commit/branch-resolve logic and the free-list checkpoint
// controller. The core side uses the master modport and the controller uses the slave modport.
interface frl_checkpoint_ctrl_if #(
  parameter int NUM_D_REG = 32,
  parameter int NUM_S_REG = 8,
  parameter int NUM_CKPT  = 4
);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int DW = $clog2(NUM_D_REG);
  localparam int SW = $clog2(NUM_S_REG);

  logic                 branch_valid;
  logic [NUM_D_REG-1:0] r_free_next;
  logic [NUM_S_REG-1:0] s_free_next;
  logic                 ckpt_full;
  logic [CW-1:0]        ckpt_id;
  logic                 resolve_valid;
  logic [CW-1:0]        resolve_id;
  logic                 resolve_mispredict;
  logic                 return_r;
  logic [DW-1:0]        return_r_addr;
  logic                 return_s;
  logic [SW-1:0]        return_s_addr;
  logic                 restore;
  logic [NUM_D_REG-1:0] restore_r_free;
  logic [NUM_S_REG-1:0] restore_s_free;
  logic [CW:0]          count;

  modport master (
    output branch_valid, r_free_next, s_free_next, resolve_valid, resolve_id,
           resolve_mispredict, return_r, return_r_addr, return_s, return_s_addr,
    input  ckpt_full, ckpt_id, restore, restore_r_free, restore_s_free, count
  );

  modport slave (
    input  branch_valid, r_free_next, s_free_next, resolve_valid, resolve_id,
           resolve_mispredict, return_r, return_r_addr, return_s, return_s_addr,
    output ckpt_full, ckpt_id, restore, restore_r_free, restore_s_free, count
  );
endinterface

// File: rtl/frl_checkpoint_ctrl.sv
// Circular buffer of speculative free-list snapshots, one per in-flight branch.
// The controller merges commit returns into live snapshots and restores a snapshot on a mispredict.
module frl_checkpoint_ctrl #(
  parameter int NUM_D_REG = 32,
  parameter int NUM_S_REG = 8,
  parameter int NUM_CKPT  = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  frl_checkpoint_ctrl_if.slave   bus
);
  localparam int CW = $clog2(NUM_CKPT);
  localparam int PW = CW + 1;

  logic [PW-1:0]        head_reg, head_next, tail_reg, tail_next;
  logic                 live_reg [NUM_CKPT];
  logic                 live_next [NUM_CKPT];
  logic                 resolved_reg [NUM_CKPT];
  logic                 resolved_next [NUM_CKPT];
  logic [NUM_D_REG-1:0] r_snap_reg [NUM_CKPT];
  logic [NUM_D_REG-1:0] r_snap_next [NUM_CKPT];
  logic [NUM_S_REG-1:0] s_snap_reg [NUM_CKPT];
  logic [NUM_S_REG-1:0] s_snap_next [NUM_CKPT];
  logic [NUM_D_REG-1:0] rbuf_reg, rbuf_next;
  logic [NUM_S_REG-1:0] sbuf_reg, sbuf_next;
  logic                 rst_pend_reg, rst_pend_next;

  logic [CW-1:0]        head_idx, tail_idx, mp_ofs;
  logic [NUM_D_REG-1:0] ret_r_vec;
  logic [NUM_S_REG-1:0] ret_s_vec;
  logic                 tgt_live, mispredict, good_resolve, head_resolved, retire, alloc;

  assign head_idx      = head_reg[CW-1:0];
  assign tail_idx      = tail_reg[CW-1:0];
  assign bus.count     = tail_reg - head_reg;
  assign bus.ckpt_full = (bus.count == PW'(NUM_CKPT));
  assign bus.ckpt_id   = tail_idx;

  assign ret_r_vec = bus.return_r ? (NUM_D_REG'(1) << bus.return_r_addr) : '0;
  assign ret_s_vec = bus.return_s ? (NUM_S_REG'(1) << bus.return_s_addr) : '0;

  assign tgt_live      = live_reg[bus.resolve_id];
  assign mispredict    = bus.resolve_valid & bus.resolve_mispredict & tgt_live;
  assign good_resolve  = bus.resolve_valid & ~bus.resolve_mispredict & tgt_live;
  // Age of the mispredicted slot relative to the oldest live slot; zero means it is the oldest.
  assign mp_ofs        = bus.resolve_id - head_idx;
  assign head_resolved = resolved_reg[head_idx] | (good_resolve & (bus.resolve_id == head_idx));
  assign retire        = live_reg[head_idx] & head_resolved & ~(mispredict & (mp_ofs == '0));
  assign alloc         = bus.branch_valid & ~bus.ckpt_full & ~mispredict;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
      logic [CW-1:0] ofs;
      logic          kill, is_alloc, is_retire, is_resolve;

      assign ofs        = CW'(gi) - head_idx;
      assign kill       = mispredict & (ofs >= mp_ofs);
      assign is_alloc   = alloc & (tail_idx == CW'(gi));
      assign is_retire  = retire & (head_idx == CW'(gi));
      assign is_resolve = good_resolve & (bus.resolve_id == CW'(gi));

      assign live_next[gi]     = is_alloc ? 1'b1 : ((kill | is_retire) ? 1'b0 : live_reg[gi]);
      assign resolved_next[gi] = is_alloc ? 1'b0 : (is_resolve ? 1'b1 : resolved_reg[gi]);
      assign r_snap_next[gi]   = is_alloc ? bus.r_free_next :
                                 (live_reg[gi] ? (r_snap_reg[gi] | ret_r_vec) : r_snap_reg[gi]);
      assign s_snap_next[gi]   = is_alloc ? bus.s_free_next :
                                 (live_reg[gi] ? (s_snap_reg[gi] | ret_s_vec) : s_snap_reg[gi]);
    end
  endgenerate

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    rbuf_next     = rbuf_reg;
    sbuf_next     = sbuf_reg;
    rst_pend_next = 1'b0;
    if (retire) begin
      head_next = head_reg + PW'(1);
    end
    if (mispredict) begin
      // Rebuild tail from head so the wrap bit always yields a smaller count.
      tail_next     = head_reg + PW'(mp_ofs);
      rbuf_next     = r_snap_reg[bus.resolve_id] | ret_r_vec;
      sbuf_next     = s_snap_reg[bus.resolve_id] | ret_s_vec;
      rst_pend_next = 1'b1;
    end else if (alloc) begin
      tail_next = tail_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      rbuf_reg     <= '0;
      sbuf_reg     <= '0;
      rst_pend_reg <= 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        live_reg[i]     <= 1'b0;
        resolved_reg[i] <= 1'b0;
      end
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      rbuf_reg     <= rbuf_next;
      sbuf_reg     <= sbuf_next;
      rst_pend_reg <= rst_pend_next;
      for (int i = 0; i < NUM_CKPT; i++) begin
        live_reg[i]     <= live_next[i];
        resolved_reg[i] <= resolved_next[i];
      end
    end
  end

  // Snapshot contents only matter while the slot is live, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      r_snap_reg[i] <= r_snap_next[i];
      s_snap_reg[i] <= s_snap_next[i];
    end
  end

  // A reset arriving in the restore cycle suppresses the pulse; same-cycle commits are folded in.
  assign bus.restore        = rst_pend_reg & n_rst;
  assign bus.restore_r_free = bus.restore ? (rbuf_reg | ret_r_vec) : '0;
  assign bus.restore_s_free = bus.restore ? (sbuf_reg | ret_s_vec) : '0;
endmodule

// File: tb/tb_frl_checkpoint_ctrl.sv
// Randomized and directed bench for frl_checkpoint_ctrl against a queue-based model of
// in-flight branch checkpoints (oldest first).
module tb_frl_checkpoint_ctrl;
  localparam int NCK = 4;

  typedef struct {
    int          id;
    logic [31:0] r;
    logic [7:0]  s;
    bit          res;
  } ckpt_t;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  ckpt_t       q[$];
  int          m_tail = 0;
  bit          m_pend = 0;
  logic [31:0] m_rbuf = '0;
  logic [7:0]  m_sbuf = '0;

  frl_checkpoint_ctrl_if #(.NUM_D_REG(32), .NUM_S_REG(8), .NUM_CKPT(NCK)) bus ();

  frl_checkpoint_ctrl #(.NUM_D_REG(32), .NUM_S_REG(8), .NUM_CKPT(NCK)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, ncyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic cyc(input bit rst_n, input bit bv, input logic [31:0] rfn, input logic [7:0] sfn,
                     input bit rv, input int rid, input bit rmp,
                     input bit rr, input int rra, input bit rs, input int rsa);
    logic [31:0] rvec;
    logic [7:0]  svec;
    bit          exp_rst, was_full, mp;
    int          j;
    @(negedge clk);
    n_rst                  = rst_n;
    bus.branch_valid       = bv;
    bus.r_free_next        = rfn;
    bus.s_free_next        = sfn;
    bus.resolve_valid      = rv;
    bus.resolve_id         = rid[1:0];
    bus.resolve_mispredict = rmp;
    bus.return_r           = rr;
    bus.return_r_addr      = rra[4:0];
    bus.return_s           = rs;
    bus.return_s_addr      = rsa[2:0];
    #1;
    rvec    = rr ? (32'd1 << rra) : 32'd0;
    svec    = rs ? (8'd1 << rsa) : 8'd0;
    exp_rst = m_pend && rst_n;
    check_val("count", bus.count, q.size());
    check_val("ckpt_full", bus.ckpt_full, q.size() == NCK);
    check_val("ckpt_id", bus.ckpt_id, m_tail);
    check_val("restore", bus.restore, exp_rst);
    check_val("restore_r_free", bus.restore_r_free, exp_rst ? (m_rbuf | rvec) : 32'd0);
    check_val("restore_s_free", bus.restore_s_free, exp_rst ? (m_sbuf | svec) : 8'd0);
    $display("cyc %0d nrst=%0b bv=%0b rv=%0b id=%0d mp=%0b rr=%0b/%0d rs=%0b/%0d cnt=%0d restore=%0b",
             ncyc, rst_n, bv, rv, rid, rmp, rr, rra, rs, rsa, bus.count, bus.restore);
    ncyc++;

    if (!rst_n) begin
      q.delete();
      m_tail = 0;
      m_pend = 0;
    end else begin
      was_full = (q.size() == NCK);
      j = -1;
      foreach (q[i]) if (q[i].id == rid) j = i;
      mp = rv && rmp && (j >= 0);
      m_pend = 0;
      foreach (q[i]) begin
        q[i].r = q[i].r | rvec;
        q[i].s = q[i].s | svec;
      end
      if (mp) begin
        m_pend = 1;
        m_rbuf = q[j].r;
        m_sbuf = q[j].s;
        while (q.size() > j) void'(q.pop_back());
        if (q.size() > 0 && q[0].res) void'(q.pop_front());
        m_tail = rid;
      end else begin
        if (rv && j >= 0) q[j].res = 1;
        if (q.size() > 0 && q[0].res) void'(q.pop_front());
        if (bv && !was_full) begin
          q.push_back('{id: m_tail, r: rfn, s: sfn, res: 1'b0});
          m_tail = (m_tail + 1) % NCK;
        end
      end
    end
  endtask

  task automatic idle();
    cyc(1, 0, 32'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input logic [31:0] rfn);
    cyc(1, 1, rfn, 8'h01, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int          rid, rra, rsa;
    bit          rst_n, bv, rv, rmp, rr, rs;
    logic [31:0] rfn;
    logic [7:0]  sfn;

    n_rst = 1'b0;
    bus.branch_valid = 0; bus.r_free_next = '0; bus.s_free_next = '0;
    bus.resolve_valid = 0; bus.resolve_id = '0; bus.resolve_mispredict = 0;
    bus.return_r = 0; bus.return_r_addr = '0; bus.return_s = 0; bus.return_s_addr = '0;

    // Reset, fill all four slots, fifth branch ignored.
    cyc(0, 0, 32'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 32'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    br(32'h0000_FFF0);
    br(32'h0000_FFE0);
    br(32'h0000_FFC0);
    br(32'h0000_FF80);
    br(32'h0000_FF00);
    idle();
    check_val("plan_count4", bus.count, 4);
    check_val("plan_full", bus.ckpt_full, 1);

    // Commit return r2, then mispredict id 1.
    cyc(1, 0, 32'd0, 8'd0, 0, 0, 0, 1, 2, 0, 0);
    cyc(1, 0, 32'd0, 8'd0, 1, 1, 1, 0, 0, 0, 0);
    idle();
    check_val("plan_restore", bus.restore, 1);
    check_val("plan_ffe4", bus.restore_r_free, 32'h0000_FFE4);
    check_val("plan_count1", bus.count, 1);
    check_val("plan_id1", bus.ckpt_id, 1);

    // Mispredict oldest with return_s 5, then return_s 6 during restore.
    cyc(1, 0, 32'd0, 8'd0, 1, 0, 1, 0, 0, 1, 5);
    cyc(1, 0, 32'd0, 8'd0, 0, 0, 0, 0, 0, 1, 6);
    check_val("plan_s56", bus.restore_s_free, 8'h61);
    check_val("plan_count0", bus.count, 0);

    // Out-of-order correct resolves.
    br(32'h1); br(32'h2); br(32'h4); br(32'h8);
    cyc(1, 0, 32'd0, 8'd0, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 32'd0, 8'd0, 1, 0, 0, 0, 0, 0, 0);
    check_val("plan_head_hold", bus.count, 4);
    idle();
    check_val("plan_count3", bus.count, 3);
    idle();
    check_val("plan_count2", bus.count, 2);

    // Branch and mispredict of id 2 in the same cycle with three live.
    cyc(0, 0, 32'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
    br(32'h10); br(32'h20); br(32'h40);
    cyc(1, 1, 32'h80, 8'h02, 1, 2, 1, 0, 0, 0, 0);
    idle();
    check_val("plan_drop_count2", bus.count, 2);
    idle();
    check_val("plan_pulse_once", bus.restore, 0);

    // Reset in the cycle the restore would assert.
    cyc(1, 0, 32'd0, 8'd0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 32'd0, 8'd0, 0, 0, 0, 1, 3, 0, 0);
    idle();
    check_val("plan_rst_count", bus.count, 0);
    check_val("plan_rst_full", bus.ckpt_full, 0);
    check_val("plan_rst_restore", bus.restore, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bv    = ($urandom_range(0, 1) == 1);
      rfn   = $urandom;
      sfn   = 8'($urandom);
      rv    = ($urandom_range(0, 9) < 4);
      rmp   = ($urandom_range(0, 3) == 0);
      if (q.size() > 0 && $urandom_range(0, 9) < 7) rid = q[$urandom_range(0, q.size() - 1)].id;
      else rid = $urandom_range(0, NCK - 1);
      rr    = ($urandom_range(0, 1) == 1);
      rra   = $urandom_range(0, 31);
      rs    = ($urandom_range(0, 1) == 1);
      rsa   = $urandom_range(0, 7);
      cyc(rst_n, bv, rfn, sfn, rv, rid, rmp, rr, rra, rs, rsa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
